// File: rtl/uart_rx_frame_fifo.sv
// Validates completed UART receive frames and buffers the data bytes, with their
// parity/framing flags, in a first-word-fall-through FIFO drained over valid/ready.
module uart_rx_frame_fifo #(
  parameter int DEPTH      = 4,
  parameter bit PARITY_ODD = 1'b1,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic             baud_clk,
  input  logic             reset,
  input  logic             frame_valid,
  input  logic [10:0]      frame_in,
  input  logic             data_ready,
  input  logic             err_clr,
  output logic [7:0]       data_out,
  output logic             data_valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun_err,
  output logic             break_det,
  output logic [CNT_W-1:0] fifo_count,
  output logic             fifo_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  // Handshake: a byte transfers on a rising edge where data_valid and data_ready
  // are both high; data_valid never depends on data_ready, and data_ready while
  // empty is ignored.

  logic [9:0]       mem_q [DEPTH];
  logic [9:0]       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overrun_q, overrun_d;
  logic             break_q, break_d;

  logic       par_bad;
  logic       frm_bad;
  logic       is_break;
  logic       push;
  logic       pop;
  logic       overrun_evt;
  logic [9:0] entry;
  logic [9:0] head;

  always_comb begin
    par_bad     = (^frame_in[9:1]) != PARITY_ODD;
    frm_bad     = frame_in[0] | ~frame_in[10];
    entry       = {frm_bad, par_bad, frame_in[8:1]};
    is_break    = frame_valid && (frame_in == 11'b0);
    pop         = data_valid && data_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    push        = frame_valid && !is_break && (!fifo_full || pop);
    overrun_evt = frame_valid && !is_break && fifo_full && !pop;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = entry;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_comb begin
    overrun_d = overrun_q;
    if (overrun_evt) begin
      overrun_d = 1'b1;
    end else if (err_clr) begin
      overrun_d = 1'b0;
    end
    break_d = is_break;
  end

  always_ff @(posedge baud_clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      break_q   <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      break_q   <= break_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the count is zero.
  always_ff @(posedge baud_clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    head        = mem_q[rd_ptr_q];
    data_valid  = (count_q != '0);
    fifo_full   = (count_q == CNT_FULL);
    fifo_count  = count_q;
    overrun_err = overrun_q;
    break_det   = break_q;
    data_out    = data_valid ? head[7:0] : 8'h00;
    parity_err  = data_valid ? head[8] : 1'b0;
    frame_err   = data_valid ? head[9] : 1'b0;
  end

endmodule

// File: tb/tb_uart_rx_frame_fifo.sv
// Directed bench for uart_rx_frame_fifo: each task drives one scenario and checks
// the outputs against hand-computed values half a cycle after the sampling edge.
module tb_uart_rx_frame_fifo;

  logic        baud_clk;
  logic        reset;
  logic        frame_valid;
  logic [10:0] frame_in;
  logic        data_ready;
  logic        err_clr;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        parity_err;
  logic        frame_err;
  logic        overrun_err;
  logic        break_det;
  logic [2:0]  fifo_count;
  logic        fifo_full;

  int checks   = 0;
  int failures = 0;

  uart_rx_frame_fifo #(.DEPTH(4), .PARITY_ODD(1'b1)) dut (
    .baud_clk    (baud_clk),
    .reset       (reset),
    .frame_valid (frame_valid),
    .frame_in    (frame_in),
    .data_ready  (data_ready),
    .err_clr     (err_clr),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .break_det   (break_det),
    .fifo_count  (fifo_count),
    .fifo_full   (fifo_full)
  );

  initial baud_clk = 1'b0;
  always #5 baud_clk = ~baud_clk;

  // Good frame: start 0, data LSB-first, odd parity, stop 1.
  function automatic logic [10:0] mk_frame(input logic [7:0] d);
    return {1'b1, ~(^d), d, 1'b0};
  endfunction

  // Inputs are applied after a falling edge, sampled on the next rising edge,
  // and this returns at the following falling edge with inputs idle again.
  task automatic step(input logic fv, input logic [10:0] fi, input logic rdy, input logic clr);
    frame_valid = fv;
    frame_in    = fi;
    data_ready  = rdy;
    err_clr     = clr;
    @(negedge baud_clk);
    frame_valid = 1'b0;
    frame_in    = 11'b0;
    data_ready  = 1'b0;
    err_clr     = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge baud_clk);
    @(negedge baud_clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", data_valid); end
    checks++; if (fifo_full !== 1'b0) begin failures++; $display("FAIL rst_full got=%b exp=0", fifo_full); end
    checks++; if (overrun_err !== 1'b0) begin failures++; $display("FAIL rst_overrun got=%b exp=0", overrun_err); end
    checks++; if (break_det !== 1'b0) begin failures++; $display("FAIL rst_break got=%b exp=0", break_det); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", fifo_count); end
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL rst_data got=%h exp=00", data_out); end
    checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL rst_par got=%b exp=0", parity_err); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL rst_frm got=%b exp=0", frame_err); end
  endtask

  task automatic test_single();
    step(1'b1, 11'b11010101010, 1'b0, 1'b0);
    checks++; if (data_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", data_valid); end
    checks++; if (data_out !== 8'h55) begin failures++; $display("FAIL single_data got=%h exp=55", data_out); end
    checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL single_par got=%b exp=0", parity_err); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL single_frm got=%b exp=0", frame_err); end
    checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", fifo_count); end
    step(1'b0, 11'b0, 1'b1, 1'b0);
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL single_pop_valid got=%b exp=0", data_valid); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL single_pop_count got=%0d exp=0", fifo_count); end
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL single_pop_data got=%h exp=00", data_out); end
  endtask

  task automatic test_pop_empty();
    step(1'b0, 11'b0, 1'b1, 1'b0);
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL empty_pop_count got=%0d exp=0", fifo_count); end
    // Push and ready together while empty: only the push takes effect.
    step(1'b1, mk_frame(8'hA7), 1'b1, 1'b0);
    checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL empty_pp_count got=%0d exp=1", fifo_count); end
    checks++; if (data_out !== 8'hA7) begin failures++; $display("FAIL empty_pp_data got=%h exp=a7", data_out); end
    step(1'b0, 11'b0, 1'b1, 1'b0);
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL empty_pp_drain got=%b exp=0", data_valid); end
  endtask

  task automatic test_error_frames();
    step(1'b1, 11'b10010101010, 1'b0, 1'b0);
    step(1'b1, 11'b01010101010, 1'b0, 1'b0);
    checks++; if (fifo_count !== 3'd2) begin failures++; $display("FAIL err_count got=%0d exp=2", fifo_count); end
    checks++; if (data_out !== 8'h55) begin failures++; $display("FAIL err_data0 got=%h exp=55", data_out); end
    checks++; if (parity_err !== 1'b1) begin failures++; $display("FAIL err_par0 got=%b exp=1", parity_err); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL err_frm0 got=%b exp=0", frame_err); end
    step(1'b0, 11'b0, 1'b1, 1'b0);
    checks++; if (data_out !== 8'h55) begin failures++; $display("FAIL err_data1 got=%h exp=55", data_out); end
    checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL err_par1 got=%b exp=0", parity_err); end
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL err_frm1 got=%b exp=1", frame_err); end
    step(1'b0, 11'b0, 1'b1, 1'b0);
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL err_drain got=%b exp=0", data_valid); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL err_drain_frm got=%b exp=0", frame_err); end
  endtask

  task automatic test_fill_overrun();
    for (int i = 1; i <= 4; i++) step(1'b1, mk_frame(8'(i)), 1'b0, 1'b0);
    checks++; if (fifo_full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", fifo_full); end
    checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", fifo_count); end
    checks++; if (overrun_err !== 1'b0) begin failures++; $display("FAIL fill_overrun got=%b exp=0", overrun_err); end
    step(1'b1, mk_frame(8'h05), 1'b0, 1'b0);
    checks++; if (overrun_err !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b exp=1", overrun_err); end
    checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL ovr_count got=%0d exp=4", fifo_count); end
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (data_out !== 8'(i)) begin failures++; $display("FAIL ovr_pop%0d got=%h exp=%h", i, data_out, 8'(i)); end
      step(1'b0, 11'b0, 1'b1, 1'b0);
    end
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL ovr_drain got=%b exp=0", data_valid); end
    checks++; if (overrun_err !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", overrun_err); end
    step(1'b0, 11'b0, 1'b0, 1'b1);
    checks++; if (overrun_err !== 1'b0) begin failures++; $display("FAIL ovr_clr got=%b exp=0", overrun_err); end
  endtask

  task automatic test_push_pop_full();
    for (int i = 0; i < 4; i++) step(1'b1, mk_frame(8'h11 + 8'(i)), 1'b0, 1'b0);
    step(1'b1, mk_frame(8'h15), 1'b1, 1'b0);
    checks++; if (overrun_err !== 1'b0) begin failures++; $display("FAIL ppf_overrun got=%b exp=0", overrun_err); end
    checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL ppf_count got=%0d exp=4", fifo_count); end
    checks++; if (data_out !== 8'h12) begin failures++; $display("FAIL ppf_head got=%h exp=12", data_out); end
    // Overrun and clear in the same cycle: the set must win.
    step(1'b1, mk_frame(8'h16), 1'b0, 1'b1);
    checks++; if (overrun_err !== 1'b1) begin failures++; $display("FAIL ppf_setwins got=%b exp=1", overrun_err); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (data_out !== 8'h12 + 8'(i)) begin failures++; $display("FAIL ppf_pop%0d got=%h exp=%h", i, data_out, 8'h12 + 8'(i)); end
      step(1'b0, 11'b0, 1'b1, 1'b0);
    end
    step(1'b0, 11'b0, 1'b0, 1'b1);
  endtask

  task automatic test_break();
    step(1'b1, mk_frame(8'h3C), 1'b0, 1'b0);
    step(1'b1, 11'b0, 1'b0, 1'b0);
    checks++; if (break_det !== 1'b1) begin failures++; $display("FAIL brk_pulse got=%b exp=1", break_det); end
    checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL brk_count got=%0d exp=1", fifo_count); end
    step(1'b0, 11'b0, 1'b0, 1'b0);
    checks++; if (break_det !== 1'b0) begin failures++; $display("FAIL brk_end got=%b exp=0", break_det); end
    for (int i = 0; i < 3; i++) step(1'b1, mk_frame(8'h40 + 8'(i)), 1'b0, 1'b0);
    // A break while full is not an overrun.
    step(1'b1, 11'b0, 1'b0, 1'b0);
    checks++; if (overrun_err !== 1'b0) begin failures++; $display("FAIL brk_full_ovr got=%b exp=0", overrun_err); end
    checks++; if (data_out !== 8'h3C) begin failures++; $display("FAIL brk_head got=%h exp=3c", data_out); end
    for (int i = 0; i < 4; i++) step(1'b0, 11'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) step(1'b1, mk_frame(8'h60 + 8'(i)), 1'b0, 1'b0);
    step(1'b0, 11'b0, 1'b1, 1'b0);
    checks++; if (fifo_count !== 3'd3) begin failures++; $display("FAIL mid_pre_count got=%0d exp=3", fifo_count); end
    checks++; if (overrun_err !== 1'b1) begin failures++; $display("FAIL mid_pre_ovr got=%b exp=1", overrun_err); end
    reset = 1'b1;
    @(negedge baud_clk);
    reset = 1'b0;
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL mid_count got=%0d exp=0", fifo_count); end
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", data_valid); end
    checks++; if (overrun_err !== 1'b0) begin failures++; $display("FAIL mid_ovr got=%b exp=0", overrun_err); end
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL mid_data got=%h exp=00", data_out); end
    step(1'b1, mk_frame(8'h9E), 1'b0, 1'b0);
    checks++; if (data_out !== 8'h9E) begin failures++; $display("FAIL mid_new got=%h exp=9e", data_out); end
    checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL mid_new_count got=%0d exp=1", fifo_count); end
  endtask

  initial begin
    reset       = 1'b1;
    frame_valid = 1'b0;
    frame_in    = 11'b0;
    data_ready  = 1'b0;
    err_clr     = 1'b0;
    @(negedge baud_clk);
    test_reset();
    test_single();
    test_pop_empty();
    test_error_frames();
    test_fill_overrun();
    test_push_pop_full();
    test_break();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_fifo.md
Name: uart_rx_frame_fifo

Overview:
- Sits directly downstream of the UART receive shift register (SIPO) in the receiver path.
- Accepts each completed 11-bit parallel frame and validates start, stop and parity.
- Buffers the data byte with per-byte error flags in a small first-word-fall-through FIFO.
- Presents bytes to the host side over a valid/ready handshake; reports overrun and break conditions.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- PARITY_ODD, 1, 1 = odd parity expected, 0 = even parity expected.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- baud_clk  input  1  system clock, same clock that drives the shift register.
- reset  input  1  synchronous, active-high reset.
- frame_valid  input  1  one-cycle pulse when frame_in holds a complete frame (driven from recieved_flag).
- frame_in  input  11  frame bits: [0] start, [8:1] data LSB-first (bit 1 = D0), [9] parity, [10] stop.
- data_ready  input  1  consumer accepts data_out this cycle.
- err_clr  input  1  clears the sticky overrun_err flag.
- data_out  output  8  head-of-FIFO data byte.
- data_valid  output  1  FIFO not empty; data_out and its flags are meaningful.
- parity_err  output  1  head entry failed the parity check.
- frame_err  output  1  head entry had start != 0 or stop != 1.
- overrun_err  output  1  sticky; a frame was dropped because the FIFO was full.
- break_det  output  1  one-cycle pulse when an all-zero frame is received.
- fifo_count  output  CNT_W  current occupancy.
- fifo_full  output  1  fifo_count == DEPTH.

Behaviour:
- Reset, sampled on the rising edge of baud_clk: pointers and count go to 0. Outputs reset to: data_valid = 0, fifo_full = 0, overrun_err = 0, break_det = 0, fifo_count = 0, data_out = 0, parity_err = 0, frame_err = 0.
- Reset mid-operation discards all stored entries.
- Frame check is combinational on frame_in:
  - par_bad = (^frame_in[9:1]) != PARITY_ODD.
  - frm_bad = frame_in[0] | ~frame_in[10].
- Entry format is {frm_bad, par_bad, data[7:0]}, 10 bits wide.
- Push: occurs when frame_valid = 1, frame_in != 0, and (fifo_full = 0 or pop occurs in the same cycle).
  - The pushed entry is visible at the head the cycle after the push edge when the FIFO was empty. Latency is frame_valid to data_valid = 1 cycle.
- Break: when frame_valid = 1 and frame_in == 11'b0, the frame is not pushed and break_det pulses high for exactly the next cycle.
- Pop: occurs when data_valid = 1 and data_ready = 1. The head advances on that edge. data_ready while empty has no effect.
- data_out, parity_err and frame_err are read from registered storage at rd_ptr (first-word fall-through). They hold 0 when empty.
- Simultaneous push and pop:
  - Count unchanged; both pointers advance.
  - Allowed when full, so no overrun in that case.
  - When empty, only the push happens, because pop requires data_valid.
- Overrun: frame_valid = 1 with a non-break frame, FIFO full and no pop in that cycle. The frame is dropped, overrun_err sets to 1 on the next edge, and stored contents are unchanged.
- overrun_err clears on err_clr = 1. If a new overrun and err_clr occur in the same cycle, set wins.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is tracked separately: +1 on push only, -1 on pop only.
- fifo_full and data_valid are decoded from the registered count.

Test Plan:
- Reset then a single frame: frame_in = 11'b11010101010 pulsed one cycle, PARITY_ODD = 1 -> next cycle data_valid = 1, data_out = 8'h55, parity_err = 0, frame_err = 0, fifo_count = 1. Then data_ready = 1 for one cycle -> data_valid = 0, fifo_count = 0.
- Error frames:
  - Push 11'b10010101010 (parity bit 0) -> head shows 8'h55 with parity_err = 1.
  - Push 11'b01010101010 (stop 0) -> frame_err = 1.
  - Both entries are stored, and the flags follow their bytes on pop.
- Fill and overrun:
  - Push 4 frames with data 8'h01..8'h04, data_ready = 0 -> fifo_full = 1, count = 4.
  - Push a 5th frame with data 8'h05 -> overrun_err = 1 and the contents are unchanged.
  - Pops return 8'h01..8'h04 in order.
  - err_clr -> overrun_err = 0.
- Push and pop while full: with count = 4, frame_valid and data_ready asserted together -> no overrun, count stays 4, the new byte appears last.
- Break: frame_in = 0 with frame_valid -> break_det high for 1 cycle, count unchanged.
- Reset mid-stream: with count = 3, assert reset for one cycle -> count = 0, data_valid = 0, overrun_err = 0, data_out = 0.
